serial_fifo_bridge: RTL and testbench

//  Bus-side buffering stage directly upstream of the external serial controller.

---
 rtl/serial_fifo_bridge_pkg.sv | 29 ++
 rtl/serial_fifo_bridge_byte_fifo.sv | 55 +++++
 rtl/serial_fifo_bridge.sv | 149 ++++++++++++++
 tb/tb_serial_fifo_bridge.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_fifo_bridge_pkg.sv
// Shared types for the serial FIFO bridge: byte/mode types, bridge FSM states, status bit positions.
// No logic; imported by the bridge top and its byte FIFO.
package serial_fifo_bridge_pkg;

    typedef logic [7:0] Byte_t;
    typedef logic [1:0] Serial_mode_t;

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_WAIT  = 2'd2
    } TxBridgeState_t;

    typedef enum logic [1:0] {
        RX_IDLE = 2'd0,
        RX_CAPT = 2'd1,
        RX_WAIT = 2'd2
    } RxBridgeState_t;

    // bus_status bit positions
    localparam int STAT_TX_NFULL  = 0;
    localparam int STAT_RX_NEMPTY = 1;
    localparam int STAT_OVERRUN   = 2;

    // ctl_mode bit positions as reported by the serial controller
    localparam int MODE_TX_IDLE  = 0;
    localparam int MODE_RX_READY = 1;

endpackage

// File: rtl/serial_fifo_bridge_byte_fifo.sv
// Show-ahead byte FIFO, 2**AW entries; dout is the head (0 when empty).
// Latency: push visible on dout the cycle after the push edge.
// Backpressure: push while full is dropped (even with a pop); pop while empty is ignored.
module byte_fifo
    import serial_fifo_bridge_pkg::*;
#(
    parameter int AW = 4
) (
    input  logic  clk,
    input  logic  rst,
    input  logic  push,
    input  logic  pop,
    input  Byte_t din,
    output Byte_t dout,
    output logic  full,
    output logic  empty
);

    localparam int DEPTH = 1 << AW;

    Byte_t         mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   cnt;
    logic          do_push;
    logic          do_pop;

    assign full    = (cnt == (AW+1)'(DEPTH));
    assign empty   = (cnt == '0);
    // full is evaluated before any same-cycle pop, so a push at full is lost
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/serial_fifo_bridge.sv
// Bus-side TX/RX byte buffering in front of the serial controller; SERIAL_BRIDGE_OVERRUN_EN adds a sticky overrun flag.
// Latency: bus_write to ctl_write_op 1 cycle when idle; ctl_mode[1] rise to bus_rdata in the 3rd cycle.
// Backpressure: bus writes to a full TX FIFO are dropped; RX full withholds ctl_read_op.
module serial_fifo_bridge
    import serial_fifo_bridge_pkg::*;
#(
    parameter int TX_AW = 4,
    parameter int RX_AW = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       bus_write,
    input  logic [7:0] bus_wdata,
    input  logic       bus_read,
    output logic [7:0] bus_rdata,
    output logic [2:0] bus_status,
    output logic       ctl_write_op,
    output logic       ctl_read_op,
    input  logic [1:0] ctl_mode,
    output logic [7:0] ctl_data_write,
    input  logic [7:0] ctl_data_read
);

    Byte_t tx_head;
    logic  tx_pop;
    logic  tx_full;
    logic  tx_empty;

    Byte_t rx_head;
    logic  rx_push;
    logic  rx_full;
    logic  rx_empty;

    TxBridgeState_t tx_state, tx_state_nxt;
    RxBridgeState_t rx_state, rx_state_nxt;
    Byte_t          tx_hold;

    byte_fifo #(.AW(TX_AW)) u_tx_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (bus_write),
        .pop   (tx_pop),
        .din   (bus_wdata),
        .dout  (tx_head),
        .full  (tx_full),
        .empty (tx_empty)
    );

    byte_fifo #(.AW(RX_AW)) u_rx_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (rx_push),
        .pop   (bus_read),
        .din   (ctl_data_read),
        .dout  (rx_head),
        .full  (rx_full),
        .empty (rx_empty)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_state <= TX_IDLE;
            rx_state <= RX_IDLE;
            tx_hold  <= '0;
        end else begin
            tx_state <= tx_state_nxt;
            rx_state <= rx_state_nxt;
            if (tx_pop) tx_hold <= tx_head;
        end
    end

    // TX: one write_op per controller idle period; the byte stays on ctl_data_write afterwards
    always_comb begin
        tx_state_nxt   = tx_state;
        tx_pop         = 1'b0;
        ctl_write_op   = 1'b0;
        ctl_data_write = tx_hold;
        case (tx_state)
            TX_IDLE: begin
                if (!tx_empty && ctl_mode[MODE_TX_IDLE]) begin
                    tx_pop         = 1'b1;
                    ctl_write_op   = 1'b1;
                    ctl_data_write = tx_head;
                    tx_state_nxt   = TX_START;
                end
            end
            TX_START: tx_state_nxt = TX_WAIT;
            TX_WAIT: begin
                if (!ctl_mode[MODE_TX_IDLE]) tx_state_nxt = TX_IDLE;
            end
            default: tx_state_nxt = TX_IDLE;
        endcase
    end

    // RX: read_op only with space available; data is valid the cycle after read_op
    always_comb begin
        rx_state_nxt = rx_state;
        ctl_read_op  = 1'b0;
        rx_push      = 1'b0;
        case (rx_state)
            RX_IDLE: begin
                if (ctl_mode[MODE_RX_READY] && !rx_full) begin
                    ctl_read_op  = 1'b1;
                    rx_state_nxt = RX_CAPT;
                end
            end
            RX_CAPT: begin
                rx_push      = 1'b1;
                rx_state_nxt = RX_WAIT;
            end
            RX_WAIT: begin
                if (!ctl_mode[MODE_RX_READY]) rx_state_nxt = RX_IDLE;
            end
            default: rx_state_nxt = RX_IDLE;
        endcase
    end

    assign bus_rdata                  = rx_head;
    assign bus_status[STAT_TX_NFULL]  = !tx_full;
    assign bus_status[STAT_RX_NEMPTY] = !rx_empty;

`ifdef SERIAL_BRIDGE_OVERRUN_EN
    logic overrun;
    logic rx_stall;
    logic rx_stall_q;

    // a single ready cycle against a full RX is tolerated; the second one flags overrun
    assign rx_stall = ctl_mode[MODE_RX_READY] && rx_full;

    always_ff @(posedge clk) begin
        if (rst) begin
            overrun    <= 1'b0;
            rx_stall_q <= 1'b0;
        end else begin
            rx_stall_q <= rx_stall;
            if ((bus_write && tx_full) || (rx_stall && rx_stall_q)) begin
                overrun <= 1'b1;
            end else if (bus_read && rx_empty) begin
                overrun <= 1'b0;
            end
        end
    end

    assign bus_status[STAT_OVERRUN] = overrun;
`else
    assign bus_status[STAT_OVERRUN] = 1'b0;
`endif

endmodule

// File: tb/tb_serial_fifo_bridge.sv
// Scoreboard bench for serial_fifo_bridge: queues hold the bytes expected in each FIFO,
// popped and compared as the DUT issues write_op or presents RX data on the bus.
module tb_serial_fifo_bridge;

    logic       clk = 1'b0;
    logic       rst;
    logic       bus_write;
    logic [7:0] bus_wdata;
    logic       bus_read;
    logic [7:0] bus_rdata;
    logic [2:0] bus_status;
    logic       ctl_write_op;
    logic       ctl_read_op;
    logic [1:0] ctl_mode;
    logic [7:0] ctl_data_write;
    logic [7:0] ctl_data_read;

    always #20 clk = ~clk;

    serial_fifo_bridge dut (
        .clk            (clk),
        .rst            (rst),
        .bus_write      (bus_write),
        .bus_wdata      (bus_wdata),
        .bus_read       (bus_read),
        .bus_rdata      (bus_rdata),
        .bus_status     (bus_status),
        .ctl_write_op   (ctl_write_op),
        .ctl_read_op    (ctl_read_op),
        .ctl_mode       (ctl_mode),
        .ctl_data_write (ctl_data_write),
        .ctl_data_read  (ctl_data_read)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // scoreboard / reference state
    logic [7:0] tx_q[$];
    logic [7:0] rx_q[$];
    logic [7:0] last_tx;
    logic [7:0] exp_rd;
    bit         capt;
    bit         ovr;
    bit         stall_q;
    bit         wop_ok;
    bit         txf;
    bit         rxf;
    bit         stall;
    bit         chk_en = 1'b0;
    int         wop_cnt = 0;
    int         rop_cnt = 0;

    // controller emulation state, driven only from the main initial block
    bit         tx_auto;
    int         busy;
    int         wop_seen;

    always @(negedge clk) begin
        if (chk_en) begin
            exp_rd = (rx_q.size() != 0) ? rx_q[0] : 8'h00;
            check("rdata", bus_rdata, exp_rd);
            check("st_tx_nfull", bus_status[0], tx_q.size() != 16);
            check("st_rx_nempty", bus_status[1], rx_q.size() != 0);
            check("st_ovr", bus_status[2], ovr);
            if (ctl_write_op) begin
                if (tx_q.size() == 0) check("wop_empty", ctl_write_op, 1'b0);
                else                  check("wop_data", ctl_data_write, tx_q[0]);
                check("wop_gap", ctl_write_op, wop_ok && ctl_mode[0]);
            end else begin
                check("dwr_hold", ctl_data_write, last_tx);
            end
            if (ctl_read_op)
                check("rop_ok", ctl_read_op, ctl_mode[1] && (rx_q.size() < 16) && !capt);
        end

        if (rst) begin
            tx_q.delete();
            rx_q.delete();
            last_tx = 8'h00;
            capt    = 1'b0;
            ovr     = 1'b0;
            stall_q = 1'b0;
            wop_ok  = 1'b1;
        end else begin
            txf   = (tx_q.size() == 16);
            rxf   = (rx_q.size() == 16);
            stall = ctl_mode[1] && rxf;
`ifdef SERIAL_BRIDGE_OVERRUN_EN
            if ((bus_write && txf) || (stall && stall_q)) ovr = 1'b1;
            else if (bus_read && rx_q.size() == 0)        ovr = 1'b0;
`endif
            stall_q = stall;
            if (ctl_write_op) begin
                wop_cnt++;
                wop_ok = 1'b0;
                if (tx_q.size() != 0) last_tx = tx_q.pop_front();
            end
            if (!ctl_mode[0]) wop_ok = 1'b1;
            if (bus_write && !txf) tx_q.push_back(bus_wdata);
            if (bus_read && rx_q.size() != 0) void'(rx_q.pop_front());
            if (capt && !rxf) rx_q.push_back(ctl_data_read);
            capt = ctl_read_op;
            if (ctl_read_op) rop_cnt++;
        end
    end

    // advance one cycle; the emulated transmitter goes busy for 3 cycles after each write_op
    task automatic tick();
        @(posedge clk);
        #1;
        if (tx_auto) begin
            if (wop_cnt != wop_seen) busy = 3;
            else if (busy != 0)      busy--;
            ctl_mode[0] = (busy == 0);
        end
        wop_seen = wop_cnt;
    endtask

    task automatic bus_wr(input logic [7:0] b);
        bus_write = 1'b1;
        bus_wdata = b;
        tick();
        bus_write = 1'b0;
    endtask

    task automatic bus_rd();
        bus_read = 1'b1;
        tick();
        bus_read = 1'b0;
    endtask

    task automatic rx_byte(input logic [7:0] b);
        ctl_data_read = b;
        ctl_mode[1]   = 1'b1;
        tick();
        ctl_mode[1]   = 1'b0;
        tick();
        tick();
    endtask

    initial begin
        #(40 * 20000);
        $display("FAIL watchdog expired");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1);
    end

    initial begin
        int w0;
        int w1;
        int r0;
        rst = 1'b1; bus_write = 1'b0; bus_wdata = 8'h00; bus_read = 1'b0;
        ctl_mode = 2'b00; ctl_data_read = 8'h00;
        tx_auto = 1'b0; busy = 0; wop_seen = 0;
        repeat (2) tick();
        rst = 1'b0;
        chk_en = 1'b1;
        check("rst_status", bus_status, 3'b001);
        check("rst_wop", ctl_write_op, 1'b0);
        check("rst_rop", ctl_read_op, 1'b0);
        check("rst_dwr", ctl_data_write, 8'h00);
        check("rst_rdata", bus_rdata, 8'h00);

        // 1: single byte with the transmitter idle
        ctl_mode = 2'b01;
        w0 = wop_cnt;
        bus_wr(8'h41);
        repeat (4) tick();
        check("t1_wop_cnt", wop_cnt - w0, 1);
        check("t1_dwr", ctl_data_write, 8'h41);
        check("t1_tx_nfull", bus_status[0], 1'b1);
        ctl_mode[0] = 1'b0;
        repeat (2) tick();

        // 2: 17 writes while busy, 17th dropped, drain 1..16 in busy periods
        for (int i = 1; i <= 17; i++) bus_wr(8'(i));
        check("t2_tx_full", bus_status[0], 1'b0);
        tx_auto = 1'b1; busy = 0; ctl_mode[0] = 1'b1;
        w0 = wop_cnt;
        for (int k = 0; k < 400 && (wop_cnt - w0) < 16; k++) tick();
        repeat (10) tick();
        check("t2_wop_cnt", wop_cnt - w0, 16);
        check("t2_last", ctl_data_write, 8'd16);

        // 3: single received byte, visible in the third cycle from the ready rise
        ctl_data_read = 8'h5A;
        r0 = rop_cnt;
        ctl_mode[1] = 1'b1;
        tick();
        ctl_mode[1] = 1'b0;
        check("t3_early", bus_rdata, 8'h00);
        tick();
        check("t3_rdata", bus_rdata, 8'h5A);
        check("t3_nempty", bus_status[1], 1'b1);
        repeat (2) tick();
        check("t3_rop_cnt", rop_cnt - r0, 1);
        bus_rd();
        check("t3_rdata0", bus_rdata, 8'h00);
        check("t3_empty", bus_status[1], 1'b0);

        // 4: RX full withholds read_op; one pop lets exactly one through
        bus_rd();
        check("t4_ovr_clr", bus_status[2], 1'b0);
        for (int i = 0; i < 16; i++) rx_byte(8'h80 + 8'(i));
        r0 = rop_cnt;
        ctl_mode[1] = 1'b1;
        repeat (8) tick();
        check("t4_no_rop", rop_cnt - r0, 0);
`ifdef SERIAL_BRIDGE_OVERRUN_EN
        check("t4_ovr_set", bus_status[2], 1'b1);
`endif
        ctl_data_read = 8'hC3;
        bus_rd();
        repeat (6) tick();
        check("t4_one_rop", rop_cnt - r0, 1);
        ctl_mode[1] = 1'b0;
        repeat (2) tick();
        for (int i = 0; i < 16; i++) bus_rd();
        check("t4_drained", bus_status[1], 1'b0);
        bus_rd();
        check("t4_ovr_end", bus_status[2], 1'b0);

        // 5: concurrent bus and controller traffic from count 8 in both FIFOs
        tx_auto = 1'b0; ctl_mode[0] = 1'b0;
        for (int i = 0; i < 8; i++) bus_wr(8'h10 + 8'(i));
        for (int i = 0; i < 8; i++) rx_byte(8'h20 + 8'(i));
        tx_auto = 1'b1; busy = 0; ctl_mode[0] = 1'b1;
        for (int i = 0; i < 24; i++) begin
            bus_write     = 1'b1;
            bus_wdata     = 8'($urandom);
            bus_read      = 1'b1;
            ctl_data_read = 8'($urandom);
            ctl_mode[1]   = (i % 4 == 0);
            tick();
        end
        bus_write = 1'b0; bus_read = 1'b0; ctl_mode[1] = 1'b0;
        for (int k = 0; k < 600 && tx_q.size() != 0; k++) tick();
        check("t5_tx_timeout", tx_q.size(), 0);
        w1 = wop_cnt;
        repeat (10) tick();
        check("t5_no_extra_wop", wop_cnt - w1, 0);
        check("t5_tx_nfull", bus_status[0], 1'b1);
        for (int k = 0; k < 40 && bus_status[1]; k++) bus_rd();
        check("t5_rx_drained", bus_status[1], 1'b0);

        // 6: reset with TX in TX_WAIT and RX in RX_CAPT
        tx_auto = 1'b0; ctl_mode = 2'b01;
        bus_wr(8'h77);
        bus_wr(8'h78);
        bus_wr(8'h79);
        repeat (3) tick();
        rx_byte(8'h33);
        ctl_data_read = 8'h44;
        ctl_mode[1] = 1'b1;
        tick();
        rst = 1'b1;
        ctl_mode = 2'b00;
        tick();
        rst = 1'b0;
        check("t6_status", bus_status, 3'b001);
        check("t6_wop", ctl_write_op, 1'b0);
        check("t6_rop", ctl_read_op, 1'b0);
        check("t6_dwr", ctl_data_write, 8'h00);
        check("t6_rdata", bus_rdata, 8'h00);
        ctl_mode = 2'b01;
        w0 = wop_cnt;
        bus_wr(8'h55);
        repeat (4) tick();
        check("t6_wop_after", wop_cnt - w0, 1);
        check("t6_dwr_after", ctl_data_write, 8'h55);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
